// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 camera-control path: FSM encoding,
// default SCCB write ID and the field layout of a register-write request.
package ov7670_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] CAMERA_ADDR_DEFAULT = 8'h42;

  // A request word is {reg_addr[15:8], value[7:0]}
  localparam int REQ_DATA_W    = 16;
  localparam int FIELD_W       = 8;
  localparam int REG_FIELD_LSB = 8;
  localparam int VAL_FIELD_LSB = 0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// ptr with wrap-around. Returns both a one-hot grant and the binary index.
module rr_arbiter
  import ov7670_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      index,
  output logic               any
);

  always_comb begin
    int c;
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        index    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Shares one SCCB sender between NUM_REQ register-write requesters with
// round-robin grant, taken/timeout handshake and an enforced idle gap.
module sccb_arbiter
  import ov7670_pkg::*;
#(
  parameter int         NUM_REQ        = 2,
  parameter logic [7:0] CAMERA_ADDR    = CAMERA_ADDR_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         GAP_CYCLES     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [REQ_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            err,
  output logic                          busy,
  output logic                          sccb_send,
  output logic [7:0]                    sccb_id,
  output logic [7:0]                    sccb_reg,
  output logic [7:0]                    sccb_value,
  input  logic                          sccb_taken
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [1:0]            state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         gnt_idx;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [NUM_REQ-1:0]    win_oh;
  logic                  gnt_any;
  logic [TW-1:0]         to_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [REQ_DATA_W-1:0] sel_data;
  logic                  arb_open;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (gnt_oh),
    .index (gnt_idx),
    .any   (gnt_any)
  );

  assign sel_data  = req_data[int'(gnt_idx)*REQ_DATA_W +: REQ_DATA_W];
  assign sccb_send = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign sccb_id   = CAMERA_ADDR;

  // Arbitrating on the last GAP cycle keeps send low for exactly GAP_CYCLES
  // between back-to-back transactions.
  assign arb_open = (state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == GAP_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      win_oh     <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      sccb_reg   <= '0;
      sccb_value <= '0;
      ack        <= '0;
      err        <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        ST_SEND: begin
          if (sccb_taken) begin
            ack     <= win_oh;
            state   <= ST_GAP;
            gap_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            err     <= win_oh;
            state   <= ST_GAP;
            gap_cnt <= '0;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          if (!arb_open) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (gnt_any) begin
            win_oh     <= gnt_oh;
            ptr        <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            sccb_reg   <= sel_data[REG_FIELD_LSB +: FIELD_W];
            sccb_value <= sel_data[VAL_FIELD_LSB +: FIELD_W];
            to_cnt     <= '0;
            state      <= ST_SEND;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter with NUM_REQ=2, TIMEOUT_CYCLES=8, GAP_CYCLES=16.
module tb_sccb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req;
  logic [31:0] req_data;
  logic [1:0]  ack, err;
  logic        busy, sccb_send, sccb_taken;
  logic [7:0]  sccb_id, sccb_reg, sccb_value;

  int n_asrt = 0;
  int n_fail = 0;
  int cnt;

  sccb_arbiter #(
    .NUM_REQ(2), .CAMERA_ADDR(8'h42), .TIMEOUT_CYCLES(8), .GAP_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .sccb_send  (sccb_send),
    .sccb_id    (sccb_id),
    .sccb_reg   (sccb_reg),
    .sccb_value (sccb_value),
    .sccb_taken (sccb_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the cycle send has just risen; taken follows dly cycles later.
  task automatic serve(input string tag, input logic [1:0] exp_ack,
                       input logic [7:0] exp_reg, input logic [7:0] exp_val, input int dly);
    chk({tag, "_send"}, sccb_send, 1'b1);
    chk({tag, "_reg"}, sccb_reg, exp_reg);
    chk({tag, "_val"}, sccb_value, exp_val);
    repeat (dly) tick();
    sccb_taken = 1'b1;
    tick();
    sccb_taken = 1'b0;
    chk({tag, "_ack"}, ack, exp_ack);
    chk({tag, "_noerr"}, err, 2'b00);
    chk({tag, "_sendlow"}, sccb_send, 1'b0);
  endtask

  // Counts send-low cycles from the ack cycle until send rises again.
  task automatic gap_len(input string tag);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sccb_send) break;
      cnt++;
    end
    chk(tag, cnt, 16);
  endtask

  initial begin
    reset_n    = 1'b0;
    req        = 2'b00;
    req_data   = '0;
    sccb_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send", sccb_send, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 2'b00);
    chk("rst_err", err, 2'b00);
    chk("rst_reg", sccb_reg, 8'h00);
    chk("rst_val", sccb_value, 8'h00);
    chk("rst_id", sccb_id, 8'h42);
    reset_n = 1'b1;
    tick();

    // Single request, taken 5 cycles after send rises
    req = 2'b01;
    req_data = {16'h0000, 16'h1280};
    tick();
    chk("single_busy", busy, 1'b1);
    chk("single_id", sccb_id, 8'h42);
    req = 2'b00;
    req_data = {16'hFFFF, 16'hFFFF};
    serve("single", 2'b01, 8'h12, 8'h80, 5);
    chk("single_gapbusy0", busy, 1'b1);
    tick();
    chk("single_ackpulse", ack, 2'b00);
    repeat (14) tick();
    chk("single_gapbusy15", busy, 1'b1);
    chk("single_gapsend", sccb_send, 1'b0);
    tick();
    chk("single_idle", busy, 1'b0);

    // Contention after reset: strict 0,1,0,1 rotation with 16-cycle gaps
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 2'b11;
    req_data = {16'h3A04, 16'h1100};
    tick();
    serve("rr0", 2'b01, 8'h11, 8'h00, 3);
    gap_len("rr_gap0");
    serve("rr1", 2'b10, 8'h3A, 8'h04, 3);
    gap_len("rr_gap1");
    serve("rr2", 2'b01, 8'h11, 8'h00, 3);
    gap_len("rr_gap2");
    req = 2'b00;
    serve("rr3", 2'b10, 8'h3A, 8'h04, 3);
    repeat (16) tick();
    chk("rr_idle", busy, 1'b0);

    // Timeout: no taken, send stays high exactly 8 cycles
    req = 2'b01;
    req_data = {16'h0000, 16'h5566};
    tick();
    req = 2'b00;
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!sccb_send) break;
      cnt++;
    end
    chk("to_sendlen", cnt, 8);
    chk("to_err", err, 2'b01);
    chk("to_noack", ack, 2'b00);
    tick();
    chk("to_errpulse", err, 2'b00);
    repeat (15) tick();
    chk("to_idle", busy, 1'b0);

    // Taken on the same cycle the timeout fires: ack wins
    req = 2'b01;
    req_data = {16'h0000, 16'h1A2B};
    tick();
    req = 2'b00;
    chk("coin_reg", sccb_reg, 8'h1A);
    repeat (7) tick();
    sccb_taken = 1'b1;
    tick();
    sccb_taken = 1'b0;
    chk("coin_ack", ack, 2'b01);
    chk("coin_noerr", err, 2'b00);
    repeat (16) tick();
    chk("coin_idle", busy, 1'b0);

    // Taken while idle is ignored
    sccb_taken = 1'b1;
    tick();
    sccb_taken = 1'b0;
    chk("idle_taken_ack", ack, 2'b00);
    chk("idle_taken_busy", busy, 1'b0);

    // Reset two cycles into SEND, then pointer must be back at 0
    req = 2'b01;
    req_data = {16'h0000, 16'h1280};
    tick();
    req = 2'b00;
    repeat (2) tick();
    chk("mid_send_pre", sccb_send, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_send", sccb_send, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_ack", ack, 2'b00);
    chk("mid_err", err, 2'b00);
    tick();
    reset_n = 1'b1;
    req = 2'b11;
    req_data = {16'h3A04, 16'h0C10};
    tick();
    req = 2'b00;
    serve("post_rst", 2'b01, 8'h0C, 8'h10, 0);
    tick();
    chk("post_rst_noerr", err, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
